// File: rtl/dp_hpd_detector.sv
// DisplayPort Hot Plug Detect qualifier.
// Synchronizes the raw HPD pin and classifies it into connect, IRQ pulse and unplug.
module dp_hpd_detector #(
    parameter int HPD_DETECT_CYC = 200000,
    parameter int IRQ_MIN_CYC    = 50000,
    parameter int IRQ_MAX_CYC    = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic HPD_Signal,
    output logic HPD_Detect,
    output logic HPD_IRQ
);

    localparam int CW = $clog2(HPD_DETECT_CYC + 1);

    localparam logic [CW-1:0] QUAL_LAST = CW'(HPD_DETECT_CYC - 1);
    localparam logic [CW-1:0] IRQ_LO    = CW'(IRQ_MIN_CYC);
    localparam logic [CW-1:0] IRQ_HI    = CW'(IRQ_MAX_CYC);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        DISCONNECTED = 2'd0,
        HIGH_QUAL    = 2'd1,
        CONNECTED    = 2'd2,
        LOW_PULSE    = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          s1;
    logic          hpd_s;
    logic          detect_nxt;
    logic          irq_nxt;

    // Two-flop synchronizer for the asynchronous HPD pin
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            hpd_s <= 1'b0;
        end else begin
            s1    <= HPD_Signal;
            hpd_s <= s1;
        end
    end

    // State register, run-length counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= DISCONNECTED;
            cnt        <= '0;
            HPD_Detect <= 1'b0;
            HPD_IRQ    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            HPD_Detect <= detect_nxt;
            HPD_IRQ    <= irq_nxt;
        end
    end

    // Next state and counter: cnt holds the length of the current run
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            DISCONNECTED: begin
                if (hpd_s) begin
                    state_nxt = HIGH_QUAL;
                    cnt_nxt   = CNT_ONE;
                end
            end
            HIGH_QUAL: begin
                if (!hpd_s) begin
                    state_nxt = DISCONNECTED;
                    cnt_nxt   = '0;
                end else if (cnt == QUAL_LAST) begin
                    state_nxt = CONNECTED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            CONNECTED: begin
                if (!hpd_s) begin
                    state_nxt = LOW_PULSE;
                    cnt_nxt   = CNT_ONE;
                end
            end
            LOW_PULSE: begin
                if (!hpd_s) begin
                    if (cnt == IRQ_HI) begin
                        state_nxt = DISCONNECTED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end else begin
                    state_nxt = CONNECTED;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = DISCONNECTED;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode: detect follows the connected states, IRQ on a valid pulse end
    always_comb begin
        detect_nxt = (state_nxt == CONNECTED) || (state_nxt == LOW_PULSE);
        irq_nxt    = (state == LOW_PULSE) && hpd_s
                     && (cnt >= IRQ_LO) && (cnt <= IRQ_HI);
    end

endmodule

// File: tb/tb_dp_hpd_detector.sv
// Self-checking bench for dp_hpd_detector.
// Directed boundary scenarios plus random pin activity against a run-length model.
module tb_dp_hpd_detector;

    localparam int DET  = 20;
    localparam int IMIN = 5;
    localparam int IMAX = 10;

    logic clk = 1'b0;
    logic reset;
    logic HPD_Signal;
    logic HPD_Detect;
    logic HPD_IRQ;

    int errors = 0;
    int checks = 0;

    // Reference model state: pin delay line and run lengths
    bit m_sync1;
    bit m_sync2;
    bit m_conn;
    bit m_irq;
    int m_high_run;
    int m_low_run;

    always #5 clk = ~clk;

    dp_hpd_detector #(
        .HPD_DETECT_CYC(DET),
        .IRQ_MIN_CYC   (IMIN),
        .IRQ_MAX_CYC   (IMAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .HPD_Signal(HPD_Signal),
        .HPD_Detect(HPD_Detect),
        .HPD_IRQ   (HPD_IRQ)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the behavioural model
    task automatic model_edge(bit rst_v, bit pin);
        bit smp;
        if (rst_v) begin
            m_sync1    = 1'b0;
            m_sync2    = 1'b0;
            m_conn     = 1'b0;
            m_irq      = 1'b0;
            m_high_run = 0;
            m_low_run  = 0;
            return;
        end
        smp     = m_sync2;
        m_sync2 = m_sync1;
        m_sync1 = pin;
        m_irq   = 1'b0;
        if (!m_conn) begin
            if (smp) begin
                m_high_run++;
                if (m_high_run == DET) begin
                    m_conn    = 1'b1;
                    m_low_run = 0;
                end
            end else begin
                m_high_run = 0;
            end
        end else begin
            if (!smp) begin
                m_low_run++;
                if (m_low_run == IMAX + 1) begin
                    m_conn     = 1'b0;
                    m_high_run = 0;
                end
            end else begin
                if (m_low_run >= IMIN) m_irq = 1'b1;
                m_low_run = 0;
            end
        end
    endtask

    // Drive one edge, advance the model, compare outputs just after the edge
    task automatic step(bit pin, bit rst_v);
        HPD_Signal = pin;
        reset      = rst_v;
        @(posedge clk);
        model_edge(rst_v, pin);
        #1;
        check("m_detect", HPD_Detect, m_conn);
        check("m_irq", HPD_IRQ, m_irq);
    endtask

    // Low pulse of L edges then high for tail edges, with edge-exact expectations
    task automatic pulse(string tag, int len, int tail, int irq_e, int fall_e);
        for (int e = 0; e < len + tail; e++) begin
            step((e >= len) ? 1'b1 : 1'b0, 1'b0);
            check({tag, "_irq"}, HPD_IRQ, (e == irq_e) ? 1 : 0);
            check({tag, "_det"}, HPD_Detect,
                  ((fall_e < 0) || (e < fall_e) || (e >= fall_e + DET)) ? 1 : 0);
        end
    endtask

    initial begin
        int lvl;
        int len;

        HPD_Signal = 1'b0;
        reset      = 1'b1;
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("rst_detect", HPD_Detect, 0);
        check("rst_irq", HPD_IRQ, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        // Connect: detect after edge 21, not before
        for (int e = 0; e <= 22; e++) begin
            step(1'b1, 1'b0);
            check("connect", HPD_Detect, (e >= DET + 1) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

        // IRQ boundaries and unplug
        pulse("glitch4", 4, 6, -1, -1);
        pulse("irq5", 5, 5, 7, -1);
        pulse("irq10", 10, 5, 12, -1);
        pulse("unplug11", 11, 25, -1, 12);

        // Back-to-back IRQ pulses 7 cycles apart
        for (int e = 0; e < 18; e++) begin
            step((e == 6 || e >= 13) ? 1'b1 : 1'b0, 1'b0);
            check("b2b_irq", HPD_IRQ, (e == 8 || e == 15) ? 1 : 0);
            check("b2b_det", HPD_Detect, 1);
        end

        // Reset in the middle of a low pulse (cnt=7 after edge 8)
        for (int e = 0; e <= 8; e++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("midrst_det", HPD_Detect, 0);
        check("midrst_irq", HPD_IRQ, 0);
        for (int e = 0; e <= 22; e++) begin
            step(1'b1, 1'b0);
            check("requal_rst", HPD_Detect, (e >= DET + 1) ? 1 : 0);
            check("requal_irq", HPD_IRQ, 0);
        end

        // Return to disconnected
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        // High run one sample short never connects
        for (int e = 0; e < 31; e++) begin
            step((e < DET - 1) ? 1'b1 : 1'b0, 1'b0);
            check("short_high", HPD_Detect, 0);
        end

        // One-edge glitch during qualification restarts it
        for (int e = 0; e < 35; e++) begin
            step((e == 10) ? 1'b0 : 1'b1, 1'b0);
            check("qual_glitch", HPD_Detect, (e >= 32) ? 1 : 0);
        end

        // Random run lengths around the thresholds, occasional resets
        lvl = 0;
        for (int r = 0; r < 250; r++) begin
            if ($urandom_range(0, 19) == 0) begin
                len = $urandom_range(1, 2);
                for (int i = 0; i < len; i++) step($urandom_range(0, 1) == 1, 1'b1);
            end
            if (lvl == 1)
                len = ($urandom_range(0, 1) == 1) ? $urandom_range(18, 30)
                                                  : $urandom_range(1, 6);
            else
                len = $urandom_range(1, 13);
            for (int i = 0; i < len; i++) step(lvl == 1, 1'b0);
            lvl = 1 - lvl;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
